// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder/subtractor.
//   state_t : FSM encoding (IDLE, RUN, DONE)
//   cnt_w() : width of the bit counter for a given operand width
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter only has to reach WIDTH-1, so $clog2(WIDTH) bits suffice
    // for every legal WIDTH (2..64).
    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder, purely combinational.
//   a, b, cin : addend bits and carry in
//   sum, cout : sum bit and carry out
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one bit per clock, LSB first, through a
// single full-adder cell whose carry is held in one flip-flop.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request, accepted in IDLE or DONE
//   sub        : 0 = a+b, 1 = a-b (captured with start)
//   a, b       : operands (captured with start)
//   busy       : high while bits are being processed
//   done       : one-cycle pulse, results valid from here on
//   sum        : WIDTH-bit result
//   carry_out  : unsigned carry (add) / not-borrow (sub)
//   overflow   : two's-complement signed overflow
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int CW = cnt_w(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_b_q, sum_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q, cout_q, ovf_q;
    logic             load, step, last;
    logic             fa_sum, fa_cout;

    assign last = (cnt_q == CW'(WIDTH - 1));

    full_adder_cell u_fa (
        .a    (op_a_q[0]),
        .b    (op_b_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    always_comb begin
        // NOTE: every signal gets a default before the case so no branch
        // leaves it unassigned, which would otherwise infer a latch.
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) state_d = DONE;
            end
            DONE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load) begin
                // Subtraction is a + ~b + 1: invert b and seed the carry.
                op_a_q  <= a;
                op_b_q  <= sub ? ~b : b;
                carry_q <= sub;
                cnt_q   <= '0;
                sum_q   <= '0;
                cout_q  <= 1'b0;
                ovf_q   <= 1'b0;
            end else if (step) begin
                sum_q   <= {fa_sum, sum_q[WIDTH-1:1]};
                op_a_q  <= op_a_q >> 1;
                op_b_q  <= op_b_q >> 1;
                carry_q <= fa_cout;
                cnt_q   <= cnt_q + 1'b1;
                if (last) begin
                    // carry_q is the carry into the MSB at this point.
                    cout_q <= fa_cout;
                    ovf_q  <= carry_q ^ fa_cout;
                end
            end
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign sum       = sum_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=4: directed vector table,
// handshake corner cases, mid-run reset and an exhaustive model sweep.
module tb_serial_adder;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] a, b;
    logic         busy, done;
    logic [W-1:0] sum;
    logic         carry_out, overflow;

    int checks   = 0;
    int failures = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sub       (sub),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         sub;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] sum;
        logic         c;
        logic         v;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called #1 after the edge that accepted start; returns cycles until
    // done and number of cycles busy was high.
    task automatic wait_done(output int lat, output int bc);
        lat = 0;
        bc  = 0;
        while (!done && lat < 20) begin
            if (busy) bc++;
            @(posedge clk);
            #1;
            lat++;
        end
        if (!done) check("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_op(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                         output int lat, output int bc);
        @(negedge clk);
        start = 1'b1;
        sub   = s;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        // Operands may change freely once captured.
        a     = W'($urandom);
        b     = W'($urandom);
        sub   = ~s;
        wait_done(lat, bc);
    endtask

    function automatic logic [W+1:0] model(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0]   r;
        logic [W-1:0] yy;
        logic         v;
        yy = s ? ~y : y;
        r  = {1'b0, x} + {1'b0, yy} + (W+1)'(s);
        v  = (x[W-1] == yy[W-1]) && (r[W-1] != x[W-1]);
        return {r[W-1:0], r[W], v};
    endfunction

    vec_t vecs[8];

    initial begin
        int lat, bc;
        bit seen;

        vecs[0] = '{1'b0, 4'd0,  4'd0, 4'b0000, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 4'd1,  4'd1, 4'b0010, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 4'd15, 4'd1, 4'b0000, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 4'd7,  4'd1, 4'b1000, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 4'd5,  4'd3, 4'b0010, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 4'd3,  4'd5, 4'b1110, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 4'd8,  4'd1, 4'b0111, 1'b1, 1'b1};
        vecs[7] = '{1'b0, 4'd2,  4'd3, 4'b0101, 1'b0, 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {busy, done, sum, carry_out, overflow}, '0);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].sub, vecs[i].a, vecs[i].b, lat, bc);
            check($sformatf("vec%0d_latency", i), lat, W);
            check($sformatf("vec%0d_busy_cycles", i), bc, W);
            check($sformatf("vec%0d_busy_in_done", i), busy, 0);
            check($sformatf("vec%0d_sum", i), sum, vecs[i].sum);
            check($sformatf("vec%0d_carry", i), carry_out, vecs[i].c);
            check($sformatf("vec%0d_ovf", i), overflow, vecs[i].v);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_done_pulse", i), done, 0);
            check($sformatf("vec%0d_hold", i), {sum, carry_out, overflow},
                  {vecs[i].sum, vecs[i].c, vecs[i].v});
        end

        // start pulse mid-RUN is ignored
        @(negedge clk);
        start = 1'b1; sub = 1'b0; a = 4'd2; b = 4'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; a = 4'd9; b = 4'd9;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("midrun_latency", lat, W - 1);
        check("midrun_sum", {sum, carry_out, overflow}, {4'b0101, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        check("midrun_no_restart", {busy, done}, 2'b00);

        // start held through DONE: back-to-back with no IDLE cycle
        @(negedge clk);
        start = 1'b1; sub = 1'b0; a = 4'd3; b = 4'd4;
        @(posedge clk);
        #1;
        wait_done(lat, bc);
        check("b2b_first_latency", lat, W);
        check("b2b_first_sum", {sum, carry_out, overflow}, {4'b0111, 1'b0, 1'b0});
        sub = 1'b1; a = 4'd6; b = 4'd5;
        @(posedge clk);
        #1;
        check("b2b_restart", {busy, done}, 2'b10);
        check("b2b_cleared", {sum, carry_out, overflow}, '0);
        start = 1'b0;
        wait_done(lat, bc);
        check("b2b_second_latency", lat, W);
        check("b2b_second_sum", {sum, carry_out, overflow}, {4'b0001, 1'b1, 1'b0});

        // Asynchronous reset on cycle 2 of RUN
        @(negedge clk);
        start = 1'b1; sub = 1'b0; a = 4'd7; b = 4'd6;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset_outputs", {busy, done, sum, carry_out, overflow}, '0);
        check("midreset_state", dut.state_q, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        check("midreset_no_resume", seen, 1'b0);
        do_op(1'b0, 4'd7, 4'd6, lat, bc);
        check("postreset_latency", lat, W);
        check("postreset_sum", {sum, carry_out, overflow}, {4'b1101, 1'b0, 1'b1});

        // Exhaustive sweep against the reference model
        for (int s = 0; s < 2; s++) begin
            for (int x = 0; x < 16; x++) begin
                for (int y = 0; y < 16; y++) begin
                    do_op(s[0], W'(x), W'(y), lat, bc);
                    check($sformatf("sweep_%s_%0d_%0d", s ? "sub" : "add", x, y),
                          {sum, carry_out, overflow}, model(s[0], W'(x), W'(y)));
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
